// File: rtl/tcam_route_loader_if.sv
// Management-side command/response handshake plus the TCAM write port.
// Latency: none, this is wiring only.
// Backpressure: cmd_valid/cmd_ready on commands, resp_valid/resp_ready on responses.
interface tcam_route_loader_if #(
    parameter int WIDTH = 32,
    parameter int IF_W  = 4
);
    logic                        cmd_valid;
    logic                        cmd_ready;
    logic [1:0]                  cmd_op;
    logic [WIDTH-1:0]            cmd_prefix;
    logic [5:0]                  cmd_len;
    logic [IF_W-1:0]             cmd_if;
    logic                        resp_valid;
    logic                        resp_ready;
    logic [2:0]                  resp_status;
    logic [7:0]                  resp_index;
    logic                        wr_en;
    logic [7:0]                  wr_index;
    logic [2*WIDTH+IF_W:0]       wr_data;

    modport master (
        output cmd_valid, cmd_op, cmd_prefix, cmd_len, cmd_if, resp_ready,
        input  cmd_ready, resp_valid, resp_status, resp_index,
        input  wr_en, wr_index, wr_data
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_prefix, cmd_len, cmd_if, resp_ready,
        output cmd_ready, resp_valid, resp_status, resp_index,
        output wr_en, wr_index, wr_data
    );
endinterface

// File: rtl/tcam_route_loader.sv
// Route TCAM writer: turns add/delete/clear commands into TCAM write strobes, keeping a shadow table.
// Latency: ADD/DEL SIZE+2 cycles to response, errors SIZE+1, bad command 1, CLEAR SIZE+1.
// Backpressure: one command in flight; cmd_ready only in IDLE, response held until resp_ready.
module tcam_route_loader #(
    parameter int WIDTH = 32,
    parameter int SIZE  = 8,
    parameter int IF_W  = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    tcam_route_loader_if.slave    bus
);
    localparam int IW    = (SIZE > 1) ? $clog2(SIZE) : 1;
    localparam int DEPTH = 1 << IW;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_DEL = 2'b01;
    localparam logic [1:0] OP_CLR = 2'b10;

    localparam logic [2:0] ST_ADDED    = 3'd0;
    localparam logic [2:0] ST_UPDATED  = 3'd1;
    localparam logic [2:0] ST_DELETED  = 3'd2;
    localparam logic [2:0] ST_CLEARED  = 3'd3;
    localparam logic [2:0] ST_FULL     = 3'd4;
    localparam logic [2:0] ST_NOTFOUND = 3'd5;
    localparam logic [2:0] ST_BADCMD   = 3'd6;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SCAN,
        S_WRITE,
        S_CLR,
        S_RESP
    } state_t;

    state_t state, state_nxt;

    logic [IW-1:0]    cnt;
    logic [1:0]       op_q;
    logic [5:0]       len_q;
    logic [IF_W-1:0]  if_q;
    logic [WIDTH-1:0] mask_q;
    logic [WIDTH-1:0] prefix_q;
    logic             match_found, free_found;
    logic [IW-1:0]    match_idx, free_idx, tgt_idx;
    logic [2:0]       st_q;
    logic [7:0]       ridx_q;

    logic             sh_vld [DEPTH];
    logic [WIDTH-1:0] sh_pfx [DEPTH];
    logic [5:0]       sh_len [DEPTH];
    logic [IF_W-1:0]  sh_if  [DEPTH];

    logic             cmd_ready_int, accept, bad_cmd, last;
    logic             hit_now, free_now, m_any, f_any;
    logic [IW-1:0]    m_idx, f_idx;
    logic [WIDTH-1:0] cmd_mask;

    // Top len bits set; a shift of WIDTH or more yields all ones, len 0 yields zero.
    function automatic logic [WIDTH-1:0] len_mask(input logic [5:0] len);
        return ~({WIDTH{1'b1}} >> len);
    endfunction

    assign cmd_ready_int = rst_n && (state == S_IDLE);
    assign accept        = bus.cmd_valid && cmd_ready_int;
    assign bad_cmd       = (int'(bus.cmd_len) > WIDTH) || (bus.cmd_op == 2'b11);
    assign cmd_mask      = len_mask(bus.cmd_len);
    assign last          = (cnt == IW'(SIZE - 1));

    assign hit_now  = sh_vld[cnt] && (sh_pfx[cnt] == prefix_q) && (sh_len[cnt] == len_q);
    assign free_now = !sh_vld[cnt];
    assign m_any    = match_found || hit_now;
    assign f_any    = free_found || free_now;
    assign m_idx    = match_found ? match_idx : cnt;
    assign f_idx    = free_found ? free_idx : cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    if (bad_cmd)                  state_nxt = S_RESP;
                    else if (bus.cmd_op == OP_CLR) state_nxt = S_CLR;
                    else                          state_nxt = S_SCAN;
                end
            end
            S_SCAN: begin
                if (last) begin
                    if (op_q == OP_ADD) state_nxt = (m_any || f_any) ? S_WRITE : S_RESP;
                    else                state_nxt = m_any ? S_WRITE : S_RESP;
                end
            end
            S_WRITE: state_nxt = S_RESP;
            S_CLR:   if (last) state_nxt = S_RESP;
            S_RESP:  if (bus.resp_ready) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt         <= '0;
            op_q        <= '0;
            len_q       <= '0;
            if_q        <= '0;
            mask_q      <= '0;
            prefix_q    <= '0;
            match_found <= 1'b0;
            free_found  <= 1'b0;
            match_idx   <= '0;
            free_idx    <= '0;
            tgt_idx     <= '0;
            st_q        <= '0;
            ridx_q      <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    cnt         <= '0;
                    match_found <= 1'b0;
                    free_found  <= 1'b0;
                    if (accept) begin
                        op_q     <= bus.cmd_op;
                        len_q    <= bus.cmd_len;
                        if_q     <= bus.cmd_if;
                        mask_q   <= cmd_mask;
                        prefix_q <= bus.cmd_prefix & cmd_mask;
                        if (bad_cmd) begin
                            st_q   <= ST_BADCMD;
                            ridx_q <= '0;
                        end
                    end
                end
                S_SCAN: begin
                    cnt <= cnt + 1'b1;
                    if (hit_now && !match_found) begin
                        match_found <= 1'b1;
                        match_idx   <= cnt;
                    end
                    if (free_now && !free_found) begin
                        free_found <= 1'b1;
                        free_idx   <= cnt;
                    end
                    // Resolve outcome using this cycle's entry as well as earlier ones.
                    if (last) begin
                        if (op_q == OP_ADD) begin
                            if (m_any) begin
                                tgt_idx <= m_idx;
                                st_q    <= ST_UPDATED;
                                ridx_q  <= 8'(m_idx);
                            end else if (f_any) begin
                                tgt_idx <= f_idx;
                                st_q    <= ST_ADDED;
                                ridx_q  <= 8'(f_idx);
                            end else begin
                                st_q    <= ST_FULL;
                                ridx_q  <= '0;
                            end
                        end else begin
                            if (m_any) begin
                                tgt_idx <= m_idx;
                                st_q    <= ST_DELETED;
                                ridx_q  <= 8'(m_idx);
                            end else begin
                                st_q    <= ST_NOTFOUND;
                                ridx_q  <= '0;
                            end
                        end
                    end
                end
                S_CLR: begin
                    cnt <= cnt + 1'b1;
                    if (last) begin
                        st_q   <= ST_CLEARED;
                        ridx_q <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) sh_vld[i] <= 1'b0;
        end else if (state == S_WRITE) begin
            sh_vld[tgt_idx] <= (op_q == OP_ADD);
        end else if (state == S_CLR) begin
            sh_vld[cnt] <= 1'b0;
        end
    end

    // Entry payload is only meaningful while its valid bit is set, so it needs no reset.
    always_ff @(posedge clk) begin
        if (state == S_WRITE && op_q == OP_ADD) begin
            sh_pfx[tgt_idx] <= prefix_q;
            sh_len[tgt_idx] <= len_q;
            sh_if[tgt_idx]  <= if_q;
        end
    end

    assign bus.cmd_ready   = cmd_ready_int;
    assign bus.resp_valid  = (state == S_RESP);
    assign bus.resp_status = (state == S_RESP) ? st_q : 3'd0;
    assign bus.resp_index  = (state == S_RESP) ? ridx_q : 8'd0;
    assign bus.wr_en       = (state == S_WRITE) || (state == S_CLR);
    assign bus.wr_index    = (state == S_WRITE) ? 8'(tgt_idx) :
                             (state == S_CLR)   ? 8'(cnt)     : 8'd0;
    assign bus.wr_data     = (state == S_WRITE && op_q == OP_ADD) ?
                             {1'b1, if_q, mask_q, prefix_q} : '0;
endmodule

// File: tb/tb_tcam_route_loader.sv
// Directed bench for tcam_route_loader (WIDTH 32, SIZE 8, IF_W 4) with hand-computed expectations.
module tb_tcam_route_loader;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    tcam_route_loader_if #(.WIDTH(32), .IF_W(4)) bus ();

    tcam_route_loader #(.WIDTH(32), .SIZE(8), .IF_W(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    logic [2:0]   r_status;
    logic [7:0]   r_index;
    int           r_lat, r_nwr, r_seq_err, r_idle_err, r_stab_err;
    logic [7:0]   r_widx_first, r_widx_last;
    logic [68:0]  r_wdat_first, r_wdat_or;

    task automatic run_cmd(input logic [1:0] op, input logic [31:0] pfx,
                           input logic [5:0] len, input logic [3:0] ifx, input int hold);
        int k;
        int guard;
        r_nwr = 0; r_seq_err = 0; r_idle_err = 0; r_stab_err = 0;
        r_widx_first = 0; r_widx_last = 0; r_wdat_first = 0; r_wdat_or = 0;
        @(negedge clk);
        bus.cmd_valid  = 1'b1;
        bus.cmd_op     = op;
        bus.cmd_prefix = pfx;
        bus.cmd_len    = len;
        bus.cmd_if     = ifx;
        guard = 0;
        while (!bus.cmd_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (!bus.cmd_ready) chk("accept_timeout", bus.cmd_ready, 1);
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        k = 0;
        while (!bus.resp_valid && k < 100) begin
            if (bus.wr_en) begin
                if (r_nwr == 0) begin
                    r_widx_first = bus.wr_index;
                    r_wdat_first = bus.wr_data;
                end
                if (int'(bus.wr_index) != int'(r_widx_first) + r_nwr) r_seq_err++;
                r_widx_last = bus.wr_index;
                r_wdat_or   = r_wdat_or | bus.wr_data;
                r_nwr++;
            end else if (bus.wr_index != 0 || bus.wr_data != 0) begin
                r_idle_err++;
            end
            @(negedge clk);
            k++;
        end
        if (!bus.resp_valid) chk("resp_timeout", bus.resp_valid, 1);
        r_lat    = k;
        r_status = bus.resp_status;
        r_index  = bus.resp_index;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            if (bus.resp_valid !== 1'b1 || bus.resp_status !== r_status ||
                bus.resp_index !== r_index || bus.wr_en !== 1'b0) r_stab_err++;
        end
        bus.resp_ready = 1'b1;
        @(negedge clk);
        bus.resp_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n          = 1'b0;
        bus.cmd_valid  = 1'b0;
        bus.cmd_op     = 2'b00;
        bus.cmd_prefix = '0;
        bus.cmd_len    = '0;
        bus.cmd_if     = '0;
        bus.resp_ready = 1'b0;
        #1;
        chk("rst_cmd_ready",  bus.cmd_ready, 0);
        chk("rst_resp_valid", bus.resp_valid, 0);
        chk("rst_status",     bus.resp_status, 0);
        chk("rst_index",      bus.resp_index, 0);
        chk("rst_wr_en",      bus.wr_en, 0);
        chk("rst_wr_index",   bus.wr_index, 0);
        chk("rst_wr_data",    bus.wr_data, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_cmd_ready", bus.cmd_ready, 1);

        // First ADD lands at index 0 with host bits cleared.
        run_cmd(2'b00, 32'h0A0B0C0D, 6'd24, 4'd3, 0);
        chk("add1_status", r_status, 0);
        chk("add1_index",  r_index, 0);
        chk("add1_lat",    r_lat, 9);
        chk("add1_nwr",    r_nwr, 1);
        chk("add1_widx",   r_widx_first, 0);
        chk("add1_wdat",   r_wdat_first, {1'b1, 4'd3, 32'hFFFFFF00, 32'h0A0B0C00});
        chk("add1_idle",   r_idle_err, 0);

        run_cmd(2'b00, 32'h0A0B0CFF, 6'd24, 4'd5, 0);
        chk("upd_status", r_status, 1);
        chk("upd_index",  r_index, 0);
        chk("upd_widx",   r_widx_first, 0);
        chk("upd_wdat",   r_wdat_first, {1'b1, 4'd5, 32'hFFFFFF00, 32'h0A0B0C00});

        for (int i = 1; i < 8; i++) begin
            run_cmd(2'b00, 32'hC0A80000 + i, 6'd32, 4'(i), 0);
            chk("fill_status", r_status, 0);
            chk("fill_index",  r_index, i);
        end

        run_cmd(2'b00, 32'h0B000001, 6'd32, 4'd1, 0);
        chk("full_status", r_status, 4);
        chk("full_index",  r_index, 0);
        chk("full_lat",    r_lat, 8);
        chk("full_nwr",    r_nwr, 0);

        run_cmd(2'b01, 32'h11111111, 6'd32, 4'd0, 0);
        chk("nf_status", r_status, 5);
        chk("nf_lat",    r_lat, 8);
        chk("nf_nwr",    r_nwr, 0);

        // Same prefix as index 3 but a different length must not match.
        run_cmd(2'b01, 32'hC0A80003, 6'd31, 4'd0, 0);
        chk("nf_len_status", r_status, 5);

        run_cmd(2'b01, 32'hC0A80003, 6'd32, 4'd0, 0);
        chk("del_status", r_status, 2);
        chk("del_index",  r_index, 3);
        chk("del_lat",    r_lat, 9);
        chk("del_nwr",    r_nwr, 1);
        chk("del_widx",   r_widx_first, 3);
        chk("del_wdat",   r_wdat_first, 0);

        run_cmd(2'b00, 32'h2222ABCD, 6'd16, 4'd7, 0);
        chk("reuse_status", r_status, 0);
        chk("reuse_index",  r_index, 3);
        chk("reuse_wdat",   r_wdat_first, {1'b1, 4'd7, 32'hFFFF0000, 32'h22220000});

        run_cmd(2'b00, 32'h01020304, 6'd33, 4'd1, 0);
        chk("bad_len_status", r_status, 6);
        chk("bad_len_index",  r_index, 0);
        chk("bad_len_lat",    r_lat, 0);
        chk("bad_len_nwr",    r_nwr, 0);

        run_cmd(2'b11, 32'h01020304, 6'd8, 4'd1, 0);
        chk("bad_op_status", r_status, 6);
        chk("bad_op_nwr",    r_nwr, 0);

        run_cmd(2'b10, 32'h0, 6'd0, 4'd0, 5);
        chk("clr_status", r_status, 3);
        chk("clr_index",  r_index, 0);
        chk("clr_lat",    r_lat, 8);
        chk("clr_nwr",    r_nwr, 8);
        chk("clr_first",  r_widx_first, 0);
        chk("clr_last",   r_widx_last, 7);
        chk("clr_seq",    r_seq_err, 0);
        chk("clr_data",   r_wdat_or, 0);
        chk("clr_hold",   r_stab_err, 0);

        run_cmd(2'b00, 32'hDEADBEEF, 6'd0, 4'd2, 0);
        chk("dflt_status", r_status, 0);
        chk("dflt_index",  r_index, 0);
        chk("dflt_wdat",   r_wdat_first, {1'b1, 4'd2, 32'h0, 32'h0});

        run_cmd(2'b00, 32'h0A000000, 6'd8, 4'd4, 0);
        chk("a8_index", r_index, 1);
        run_cmd(2'b00, 32'h0B000000, 6'd8, 4'd6, 0);
        chk("b8_index", r_index, 2);

        // Reset in the middle of a CLEAR: write strobe must fall without a clock edge.
        @(negedge clk);
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = 2'b10;
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        @(negedge clk);
        chk("midclr_wr_en", bus.wr_en, 1);
        chk("midclr_index", bus.wr_index, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_wr_en",     bus.wr_en, 0);
        chk("midrst_wr_index",  bus.wr_index, 0);
        chk("midrst_cmd_ready", bus.cmd_ready, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("postrst_cmd_ready", bus.cmd_ready, 1);

        // Shadow was wiped by reset, so this lands in slot 0 as a fresh add.
        run_cmd(2'b00, 32'h0B000000, 6'd8, 4'd1, 0);
        chk("postrst_status", r_status, 0);
        chk("postrst_index",  r_index, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
